// File: rtl/risc8_run_ctrl.sv
// Run controller for the risc8 core: reset pulse, run enable, halt/stall/timeout detection.
// Optional PC trace buffer when RISC8_RUN_TRACE_EN is defined; otherwise o_trace_pc reads 0.
module risc8_run_ctrl #(
    parameter int PC_W        = 16,
    parameter int CNT_W       = 16,
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 300,
    parameter int STALL_LIMIT = 8,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic                           i_cpu_done,
    input  logic [PC_W-1:0]                i_cpu_pc,
    output logic                           o_cpu_reset,
    output logic                           o_cpu_run,
    output logic                           o_busy,
    output logic                           o_finished,
    output logic [1:0]                     o_status,
    output logic [CNT_W-1:0]               o_cycle_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] i_trace_idx,
    output logic [PC_W-1:0]                o_trace_pc
);
    // state     | meaning
    // S_IDLE    | core held in reset, waiting for start
    // S_RESET   | reset pulse to core, RST_CYCLES long
    // S_RUN     | core executing, cycles counted
    // S_HALTED  | core signalled done
    // S_TIMEOUT | cycle budget exhausted
    // S_STALLED | PC unchanged for STALL_LIMIT run cycles
    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_RUN, S_HALTED, S_TIMEOUT, S_STALLED
    } state_t;

    localparam int RST_W   = $clog2(RST_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic [PC_W-1:0]    r_last_pc;
    logic [CNT_W-1:0]   r_cycle_count;
    logic               r_cpu_reset, r_cpu_run, r_busy, r_finished;
    logic [1:0]         r_status;
    logic [1:0]         w_status_nxt;
    logic               w_pc_same, w_enter_reset, w_enter_run, w_run_step;

    assign w_pc_same     = (i_cpu_pc == r_last_pc);
    assign w_enter_reset = (w_state_nxt == S_RESET) && (r_state != S_RESET);
    assign w_enter_run   = (r_state == S_RESET) && (w_state_nxt == S_RUN);
    assign w_run_step    = (r_state == S_RUN) && !i_abort;

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = 2'd0;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RESET;
            S_RESET: if (r_rst_cnt == '0) w_state_nxt = S_RUN;
            S_RUN: begin
                if (i_cpu_done)
                    w_state_nxt = S_HALTED;
                else if (w_pc_same && (r_stall_cnt == STALL_W'(STALL_LIMIT - 1)))
                    w_state_nxt = S_STALLED;
                else if (r_cycle_count == CNT_W'(MAX_CYCLES - 1))
                    w_state_nxt = S_TIMEOUT;
            end
            S_HALTED, S_TIMEOUT, S_STALLED: if (i_start) w_state_nxt = S_RESET;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_abort) w_state_nxt = S_IDLE;
        case (w_state_nxt)
            S_HALTED:  w_status_nxt = 2'd1;
            S_TIMEOUT: w_status_nxt = 2'd2;
            S_STALLED: w_status_nxt = 2'd3;
            default:   w_status_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cpu_reset   <= 1'b1;
            r_cpu_run     <= 1'b0;
            r_busy        <= 1'b0;
            r_finished    <= 1'b0;
            r_status      <= 2'd0;
            r_cycle_count <= '0;
            r_rst_cnt     <= '0;
            r_stall_cnt   <= '0;
            r_last_pc     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cpu_reset <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RESET);
            r_cpu_run   <= (w_state_nxt == S_RUN);
            r_busy      <= (w_state_nxt == S_RESET) || (w_state_nxt == S_RUN);
            r_finished  <= (w_state_nxt == S_HALTED) || (w_state_nxt == S_TIMEOUT)
                           || (w_state_nxt == S_STALLED);
            r_status    <= w_status_nxt;

            if (w_enter_reset) begin
                r_rst_cnt     <= RST_W'(RST_CYCLES - 1);
                r_cycle_count <= '0;
            end else begin
                if ((r_state == S_RESET) && (r_rst_cnt != '0))
                    r_rst_cnt <= r_rst_cnt - RST_W'(1);
                if (w_run_step)
                    r_cycle_count <= r_cycle_count + CNT_W'(1);
            end

            // Last PC is taken at the RESET->RUN edge so the first run cycle compares against it
            if (w_enter_run) begin
                r_last_pc   <= i_cpu_pc;
                r_stall_cnt <= '0;
            end else if (w_run_step) begin
                r_last_pc   <= i_cpu_pc;
                r_stall_cnt <= w_pc_same ? (r_stall_cnt + STALL_W'(1)) : '0;
            end
        end
    end

    assign o_cpu_reset   = r_cpu_reset;
    assign o_cpu_run     = r_cpu_run;
    assign o_busy        = r_busy;
    assign o_finished    = r_finished;
    assign o_status      = r_status;
    assign o_cycle_count = r_cycle_count;

`ifdef RISC8_RUN_TRACE_EN
    localparam int IDX_W = $clog2(TRACE_DEPTH);

    logic [PC_W-1:0]  r_trace [TRACE_DEPTH];
    logic [IDX_W-1:0] r_wptr;
    logic [IDX_W-1:0] w_rd_idx;

    always_ff @(posedge clk) begin
        if (reset || w_enter_reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++) r_trace[i] <= '0;
            r_wptr <= '0;
        end else if (w_run_step && !w_pc_same) begin
            r_trace[r_wptr] <= i_cpu_pc;
            r_wptr          <= r_wptr + IDX_W'(1);
        end
    end

    // Index 0 is the newest entry; pointer arithmetic wraps at the power-of-2 depth
    assign w_rd_idx   = r_wptr - IDX_W'(1) - i_trace_idx;
    assign o_trace_pc = r_trace[w_rd_idx];
`else
    logic w_unused_trace;
    assign w_unused_trace = ^i_trace_idx;
    assign o_trace_pc     = '0;
`endif

endmodule

// File: tb/tb_risc8_run_ctrl.sv
// Self-checking bench for risc8_run_ctrl: randomized runs against a cycle-by-cycle behavioural model.
module tb_risc8_run_ctrl;
    localparam int PC_W        = 16;
    localparam int CNT_W       = 16;
    localparam int RST_CYCLES  = 2;
    localparam int MAX_CYCLES  = 300;
    localparam int STALL_LIMIT = 8;
    localparam int TRACE_DEPTH = 8;

    logic             clk;
    logic             reset;
    logic             i_start, i_abort, i_cpu_done;
    logic [PC_W-1:0]  i_cpu_pc;
    logic             o_cpu_reset, o_cpu_run, o_busy, o_finished;
    logic [1:0]       o_status;
    logic [CNT_W-1:0] o_cycle_count;
    logic [2:0]       i_trace_idx;
    logic [PC_W-1:0]  o_trace_pc;

    int checks = 0;
    int errors = 0;

    logic [PC_W-1:0] pcs [0:MAX_CYCLES+8];

    risc8_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES),
        .STALL_LIMIT(STALL_LIMIT), .TRACE_DEPTH(TRACE_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
        .i_cpu_done(i_cpu_done), .i_cpu_pc(i_cpu_pc), .o_cpu_reset(o_cpu_reset),
        .o_cpu_run(o_cpu_run), .o_busy(o_busy), .o_finished(o_finished),
        .o_status(o_status), .o_cycle_count(o_cycle_count),
        .i_trace_idx(i_trace_idx), .o_trace_pc(o_trace_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walk the run cycle by cycle: count consecutive unchanged PCs; done beats stall beats timeout.
    task automatic model_run(input logic [PC_W-1:0] pc0, input int done_cyc,
                             output int st, output int cnt);
        logic [PC_W-1:0] prev;
        int eq;
        prev = pc0;
        eq   = 0;
        st   = 0;
        cnt  = 0;
        for (int n = 1; n <= MAX_CYCLES; n++) begin
            eq   = (pcs[n] == prev) ? eq + 1 : 0;
            prev = pcs[n];
            if (n == done_cyc)     begin st = 1; cnt = n; return; end
            if (eq >= STALL_LIMIT) begin st = 3; cnt = n; return; end
            if (n == MAX_CYCLES)   begin st = 2; cnt = n; return; end
        end
    endtask

    task automatic run_sequence(input string name, input logic [PC_W-1:0] pc0,
                                input int done_cyc, input bit noise);
        int exp_st, exp_cnt, rst_obs;
        bit fin;
        model_run(pc0, done_cyc, exp_st, exp_cnt);
        i_cpu_pc   = pc0;
        i_cpu_done = 1'b0;
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        checks++;
        if (o_cycle_count !== '0 || o_status !== 2'd0 || o_finished !== 1'b0 || o_busy !== 1'b1)
            begin errors++; $display("FAIL %s start: count=%0d status=%0d fin=%b busy=%b, expected 0/0/0/1",
                                     name, o_cycle_count, o_status, o_finished, o_busy); end
        rst_obs = 0;
        while (o_cpu_reset === 1'b1 && rst_obs < 16) begin
            rst_obs++;
            i_cpu_done = 1'($urandom_range(0, 1));
            step();
        end
        checks++;
        if (rst_obs != RST_CYCLES)
            begin errors++; $display("FAIL %s reset_len: got %0d expected %0d", name, rst_obs, RST_CYCLES); end
        checks++;
        if (o_cpu_run !== 1'b1 || o_busy !== 1'b1 || o_cycle_count !== '0)
            begin errors++; $display("FAIL %s run_entry: run=%b busy=%b count=%0d, expected 1/1/0",
                                     name, o_cpu_run, o_busy, o_cycle_count); end
        fin = 1'b0;
        for (int n = 1; n <= MAX_CYCLES + 4 && !fin; n++) begin
            i_cpu_pc   = pcs[n];
            i_cpu_done = (n == done_cyc);
            i_start    = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            step();
            if (o_finished === 1'b1) fin = 1'b1;
            else begin
                checks++;
                if (o_cpu_run !== 1'b1 || o_cycle_count !== CNT_W'(n))
                    begin errors++; $display("FAIL %s running: run=%b count=%0d expected 1/%0d",
                                             name, o_cpu_run, o_cycle_count, n); end
            end
        end
        i_start    = 1'b0;
        i_cpu_done = 1'b0;
        checks++;
        if (!fin) begin errors++; $display("FAIL %s no_terminal: finished=%b expected 1", name, o_finished); end
        checks++;
        if (o_status !== 2'(exp_st))
            begin errors++; $display("FAIL %s status: got %0d expected %0d", name, o_status, exp_st); end
        checks++;
        if (o_cycle_count !== CNT_W'(exp_cnt))
            begin errors++; $display("FAIL %s count: got %0d expected %0d", name, o_cycle_count, exp_cnt); end
        checks++;
        if (o_cpu_run !== 1'b0 || o_cpu_reset !== 1'b0 || o_busy !== 1'b0)
            begin errors++; $display("FAIL %s terminal_outputs: run=%b rst=%b busy=%b expected 0/0/0",
                                     name, o_cpu_run, o_cpu_reset, o_busy); end
        for (int k = 0; k < 3; k++) begin
            i_cpu_pc   = PC_W'($urandom);
            i_cpu_done = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (o_cycle_count !== CNT_W'(exp_cnt) || o_status !== 2'(exp_st) || o_finished !== 1'b1)
                begin errors++; $display("FAIL %s frozen: count=%0d status=%0d fin=%b expected %0d/%0d/1",
                                         name, o_cycle_count, o_status, o_finished, exp_cnt, exp_st); end
        end
        i_cpu_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (o_cpu_reset !== 1'b1 || o_cpu_run !== 1'b0 || o_busy !== 1'b0 || o_finished !== 1'b0
            || o_status !== 2'd0 || o_cycle_count !== '0 || o_trace_pc !== '0)
            begin errors++; $display("FAIL reset_state: rst=%b run=%b busy=%b fin=%b status=%0d count=%0d trace=%0h",
                                     o_cpu_reset, o_cpu_run, o_busy, o_finished, o_status, o_cycle_count, o_trace_pc); end
        reset = 1'b0;
        step();
        checks++;
        if (o_cpu_reset !== 1'b1 || o_busy !== 1'b0)
            begin errors++; $display("FAIL idle_hold: rst=%b busy=%b expected 1/0", o_cpu_reset, o_busy); end
    endtask

    task automatic test_halt();
        for (int n = 0; n <= MAX_CYCLES + 8; n++) pcs[n] = PC_W'(16'h0100 + n);
        run_sequence("halt", 16'h0100, 20, 1'b0);
        checks++;
        if (o_status !== 2'd1 || o_cycle_count !== CNT_W'(20))
            begin errors++; $display("FAIL halt_spec: status=%0d count=%0d expected 1/20", o_status, o_cycle_count); end
    endtask

    task automatic test_stall();
        for (int n = 0; n <= MAX_CYCLES + 8; n++) pcs[n] = (n < 5) ? PC_W'(16'h0010 + n) : 16'h0042;
        run_sequence("stall", 16'h0010, 0, 1'b0);
        checks++;
        if (o_status !== 2'd3 || o_cycle_count !== CNT_W'(13))
            begin errors++; $display("FAIL stall_spec: status=%0d count=%0d expected 3/13", o_status, o_cycle_count); end
        run_sequence("stall_tie", 16'h0010, 13, 1'b0);
        checks++;
        if (o_status !== 2'd1 || o_cycle_count !== CNT_W'(13))
            begin errors++; $display("FAIL tie_spec: status=%0d count=%0d expected 1/13", o_status, o_cycle_count); end
    endtask

    task automatic test_timeout();
        pcs[0] = '0;
        for (int n = 1; n <= MAX_CYCLES + 8; n++) pcs[n] = pcs[n-1] + PC_W'($urandom_range(1, 4));
        run_sequence("timeout", 16'h0000, 0, 1'b0);
        checks++;
        if (o_status !== 2'd2 || o_cycle_count !== CNT_W'(MAX_CYCLES))
            begin errors++; $display("FAIL timeout_spec: status=%0d count=%0d expected 2/%0d",
                                     o_status, o_cycle_count, MAX_CYCLES); end
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        checks++;
        if (o_cpu_reset !== 1'b1 || o_busy !== 1'b1 || o_cycle_count !== '0 || o_status !== 2'd0 || o_finished !== 1'b0)
            begin errors++; $display("FAIL restart: rst=%b busy=%b count=%0d status=%0d fin=%b expected 1/1/0/0/0",
                                     o_cpu_reset, o_busy, o_cycle_count, o_status, o_finished); end
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_cpu_reset !== 1'b1)
            begin errors++; $display("FAIL abort_reset: busy=%b rst=%b expected 0/1", o_busy, o_cpu_reset); end
    endtask

    task automatic test_abort();
        i_cpu_pc = 16'h0200;
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 0; k < RST_CYCLES; k++) step();
        for (int n = 1; n <= 10; n++) begin
            i_cpu_pc = PC_W'(16'h0200 + n);
            i_start  = (n == 5);
            i_abort  = (n == 10);
            step();
            if (n == 7) begin
                checks++;
                if (o_cycle_count !== CNT_W'(7) || o_cpu_run !== 1'b1)
                    begin errors++; $display("FAIL start_while_busy: count=%0d run=%b expected 7/1",
                                             o_cycle_count, o_cpu_run); end
            end
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        checks++;
        if (o_cpu_reset !== 1'b1 || o_cpu_run !== 1'b0 || o_busy !== 1'b0 || o_finished !== 1'b0 || o_status !== 2'd0)
            begin errors++; $display("FAIL abort_run: rst=%b run=%b busy=%b fin=%b status=%0d expected 1/0/0/0/0",
                                     o_cpu_reset, o_cpu_run, o_busy, o_finished, o_status); end
        i_abort = 1'b1;
        i_start = 1'b1;
        step();
        i_abort = 1'b0;
        i_start = 1'b0;
        step();
        checks++;
        if (o_cpu_reset !== 1'b1 || o_busy !== 1'b0)
            begin errors++; $display("FAIL abort_beats_start: rst=%b busy=%b expected 1/0", o_cpu_reset, o_busy); end
    endtask

    task automatic test_random();
        logic [PC_W-1:0] pc0;
        int n, len, done_cyc;
        for (int r = 0; r < 6; r++) begin
            pc0    = PC_W'($urandom);
            pcs[0] = pc0;
            n      = 1;
            while (n <= MAX_CYCLES + 8) begin
                if ($urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 10);
                    for (int k = 0; k < len && n <= MAX_CYCLES + 8; k++) begin pcs[n] = pcs[n-1]; n++; end
                end else begin
                    pcs[n] = pcs[n-1] + PC_W'($urandom_range(1, 100));
                    n++;
                end
            end
            done_cyc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, MAX_CYCLES) : 0;
            run_sequence($sformatf("random%0d", r), pc0, done_cyc, 1'b1);
        end
    endtask

    task automatic test_trace();
        logic [PC_W-1:0] hist[$];
        logic [PC_W-1:0] prev, exp_pc;
        for (int n = 0; n <= MAX_CYCLES + 8; n++) pcs[n] = (n <= 10) ? PC_W'(n) : 16'd10;
        run_sequence("trace", 16'h0000, 11, 1'b0);
        prev = '0;
        for (int n = 1; n <= 11; n++) begin
            if (pcs[n] != prev) hist.push_back(pcs[n]);
            prev = pcs[n];
        end
        for (int idx = 0; idx < TRACE_DEPTH; idx++) begin
            i_trace_idx = 3'(idx);
            #1;
`ifdef RISC8_RUN_TRACE_EN
            exp_pc = (idx < hist.size()) ? hist[hist.size() - 1 - idx] : '0;
`else
            exp_pc = '0;
`endif
            checks++;
            if (o_trace_pc !== exp_pc)
                begin errors++; $display("FAIL trace_idx%0d: got %0d expected %0d", idx, o_trace_pc, exp_pc); end
        end
        i_trace_idx = '0;
    endtask

    initial begin
        reset       = 1'b1;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_cpu_done  = 1'b0;
        i_cpu_pc    = '0;
        i_trace_idx = '0;
        test_reset();
        test_halt();
        test_stall();
        test_timeout();
        test_abort();
        test_random();
        test_trace();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
